i2c_slave_mem: RTL and testbench
================================

# i2c_slave_mem

Synthesizable I2C target with a byte-addressed register memory, placed on the I2C bus directly downstream of the i2cmb master. It consumes the SCL/SDA traffic the master produces, serving as a real on-chip peer for closed-loop regression. A write sets an internal pointer and stores data bytes. A read returns bytes from the pointer. Only the target's address/data direction is implemented; SCL is never stretched.

## Interface
- SLAVE_ADDR, 7'h22, 7-bit target address matched after START.
- MEM_AW, 4, memory address width; depth is 2^MEM_AW bytes.
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronizers (≥2).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- scl_i  in  1  bus SCL level (asynchronous).
- sda_i  in  1  bus SDA level (asynchronous).
- sda_pull_o  out  1  1 = drive SDA low (open-drain enable); 0 = release.
- busy_o  out  1  high while this target is addressed (address ACKed until STOP/START).
- start_o  out  1  one-cycle pulse per START or repeated START detected.
- stop_o  out  1  one-cycle pulse per STOP detected.
- wr_o  out  1  one-cycle pulse when a data byte is written to memory.
- dbg_addr_i  in  MEM_AW  backdoor read address.
- dbg_data_o  out  8  mem[dbg_addr_i], combinational.

## Operation
- Inputs pass through SYNC_STAGES flops, plus one history flop for edge detect.
- SCL rise samples SDA. All SDA changes by this block occur on SCL fall.
- START is SDA 1→0 while SCL high. STOP is SDA 0→1 while SCL high. Both take priority over bit processing in every state.
- States:
  - IDLE.
  - ADDR: 8 bits, address plus R/W.
  - ADDR_ACK.
  - PTR: pointer byte.
  - PTR_ACK.
  - WDATA.
  - WDATA_ACK.
  - RDATA.
  - RD_MACK: master ACK/NACK slot.
  - IGNORE.
- START from any state → ADDR, bit count = 0, pointer kept.
- STOP → IDLE, sda_pull_o = 0.
- ADDR, after 8 bits:
  - Match with W → ACK, then PTR.
  - Match with R → ACK, then RDATA.
  - Mismatch → no ACK, IGNORE.
- PTR: pointer loads byte[MEM_AW-1:0]; upper bits are discarded. ACK, then WDATA.
- WDATA: byte written to mem[ptr], wr_o pulses, ptr increments. ACK, then WDATA again.
- RDATA: shift mem[ptr] out MSB first. Each bit drives sda_pull_o = ~bit. Release SDA after bit 0.
- RD_MACK: ptr increments regardless of the master's response.
  - Master ACK (SDA=0) → RDATA, next byte.
  - NACK → IGNORE.
- Pointer and memory wrap modulo 2^MEM_AW.
- IGNORE holds sda_pull_o = 0 until START or STOP.

## Timing
- Reset values: all outputs 0, state IDLE, ptr 0, memory all 0x00.
- Bus input to internal edge detect latency: SYNC_STAGES+1 clk_i cycles.
- Input timing requirements: SCL high and SCL low each ≥ SYNC_STAGES+3 clk_i cycles. SDA setup to SCL rise ≥ 2 cycles.
- ACK drive: sda_pull_o asserts 1 cycle after the detected SCL fall that ends bit 8. It releases 1 cycle after the next detected SCL fall.
- Read data drive: changes 1 cycle after each detected SCL fall.
- wr_o and memory write occur 1 cycle after the SCL rise of bit 8 (before ACK).
- start_o and stop_o pulse 1 cycle after detection.
- busy_o rises with ADDR_ACK entry and falls with the stop_o or start_o pulse.
- Simultaneous SCL and SDA edges in one synchronized sample: SCL edge wins; no START/STOP is inferred.
- rst_n_i assertion mid-byte releases SDA immediately (asynchronously).

## Structure
- Shared package i2c_slave_pkg holds:
  - the state enum;
  - I2C_ACK = 1'b0 and I2C_NACK = 1'b1;
  - localparam BYTE_W = 8.
- One sub-module, i2c_bus_sync: synchronizers plus edge detection. Outputs are scl_rise, scl_fall, start_det and stop_det.
- Memory is a flop array, not a RAM macro.

## Test plan
- Write 0x22+W, ptr 0x03, data 0xA5, 0x5A, STOP → three ACKs, two wr_o pulses. Backdoor reads give mem[3]=0xA5 and mem[4]=0x5A.
- Write ptr 0x03 then repeated START 0x22+R; master ACKs the first byte and NACKs the second → bus shows 0xA5 then 0x5A. A third byte is never driven. Final ptr is 5.
- Address 0x23 → SDA never pulled low through STOP, busy_o stays 0, memory unchanged.
- Write ptr 0x0F, data 0x11, 0x22 → mem[15]=0x11 and mem[0]=0x22 (wrap).
- STOP issued after 4 bits of a data byte → no wr_o, IDLE, memory unchanged. A new START is accepted.
- rst_n_i pulled low during the read drive of a 0-bit → sda_pull_o is 0 within the same cycle. Memory reads back 0x00.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared types and constants for the i2c_slave_mem target
package i2c_slave_pkg;
  localparam int BYTE_W = 8;
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE
  } state_t;
endpackage

// File: rtl/i2c_slave_mem_bus_sync.sv
// i2c_bus_sync: SCL/SDA synchronizers plus edge, START and STOP detection
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_lvl
);
  logic [SYNC_STAGES-1:0] scl_sr, sda_sr;
  logic scl_d, sda_d, scl_s;
  // idle bus is high, so reset to 1 to avoid phantom edges after reset
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_i};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_i};
      scl_d <= scl_sr[SYNC_STAGES-1];
      sda_d <= sda_sr[SYNC_STAGES-1];
    end
  assign scl_s = scl_sr[SYNC_STAGES-1];
  assign sda_lvl = sda_sr[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  // SCL must be high in both samples, so a coincident SCL edge suppresses START/STOP
  assign start_det = scl_s & scl_d & sda_d & ~sda_lvl;
  assign stop_det = scl_s & scl_d & ~sda_d & sda_lvl;
endmodule

// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C target with pointer-addressed byte register memory
module i2c_slave_mem
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h22,
  parameter int MEM_AW = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_pull_o,
  output logic busy_o,
  output logic start_o,
  output logic stop_o,
  output logic wr_o,
  input  logic [MEM_AW-1:0] dbg_addr_i,
  output logic [BYTE_W-1:0] dbg_data_o
);
  logic scl_rise, scl_fall, start_det, stop_det, sda_lvl;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [BYTE_W-1:0] shreg, shreg_n, tx, tx_n, byte_in;
  logic [MEM_AW-1:0] ptr, ptr_n;
  logic rw, rw_n, pull_n, busy_n, start_n, stop_n, wr_n, we;
  logic [BYTE_W-1:0] mem [2**MEM_AW];

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .scl_i(scl_i), .sda_i(sda_i),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det),
    .stop_det(stop_det), .sda_lvl(sda_lvl)
  );

  assign byte_in = {shreg[BYTE_W-2:0], sda_lvl};
  assign dbg_data_o = mem[dbg_addr_i];

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shreg_n = shreg;
    tx_n = tx;
    ptr_n = ptr;
    rw_n = rw;
    pull_n = sda_pull_o;
    busy_n = busy_o;
    start_n = 1'b0;
    stop_n = 1'b0;
    wr_n = 1'b0;
    we = 1'b0;
    if (start_det) begin
      state_n = ADDR;
      cnt_n = '0;
      pull_n = 1'b0;
      busy_n = 1'b0;
      start_n = 1'b1;
    end else if (stop_det) begin
      state_n = IDLE;
      pull_n = 1'b0;
      busy_n = 1'b0;
      stop_n = 1'b1;
    end else
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise && cnt != 4'd8) begin
            shreg_n = byte_in;
            cnt_n = cnt + 4'd1;
          end
          if (state == WDATA && scl_rise && cnt == 4'd7) begin
            we = 1'b1;
            wr_n = 1'b1;
            ptr_n = ptr + MEM_AW'(1);
          end
          if (scl_fall && cnt == 4'd8) begin
            cnt_n = '0;
            if (state == ADDR) begin
              state_n = shreg[7:1] == SLAVE_ADDR ? ADDR_ACK : IGNORE;
              pull_n = shreg[7:1] == SLAVE_ADDR ? ~I2C_ACK : 1'b0;
              busy_n = shreg[7:1] == SLAVE_ADDR;
              rw_n = shreg[0];
            end else begin
              state_n = state == PTR ? PTR_ACK : WDATA_ACK;
              pull_n = ~I2C_ACK;
              ptr_n = state == PTR ? shreg[MEM_AW-1:0] : ptr;
            end
          end
        end
        ADDR_ACK:
          if (scl_fall) begin
            cnt_n = '0;
            state_n = rw ? RDATA : PTR;
            tx_n = mem[ptr];
            pull_n = rw & ~mem[ptr][BYTE_W-1];
          end
        PTR_ACK, WDATA_ACK:
          if (scl_fall) begin
            cnt_n = '0;
            state_n = WDATA;
            pull_n = 1'b0;
          end
        RDATA: begin
          if (scl_rise) cnt_n = cnt + 4'd1;
          if (scl_fall && cnt == 4'd8) begin
            cnt_n = '0;
            state_n = RD_MACK;
            pull_n = 1'b0;
          end else if (scl_fall) begin
            tx_n = {tx[BYTE_W-2:0], 1'b0};
            pull_n = ~tx[BYTE_W-2];
          end
        end
        // cnt marks a sampled master ACK so the next fall starts the next byte
        RD_MACK:
          if (scl_rise) begin
            ptr_n = ptr + MEM_AW'(1);
            cnt_n = sda_lvl == I2C_ACK ? 4'd1 : 4'd0;
            state_n = sda_lvl == I2C_NACK ? IGNORE : RD_MACK;
          end else if (scl_fall && cnt != 4'd0) begin
            cnt_n = '0;
            state_n = RDATA;
            tx_n = mem[ptr];
            pull_n = ~mem[ptr][BYTE_W-1];
          end
        default: ;
      endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      tx <= '0;
      ptr <= '0;
      rw <= 1'b0;
      sda_pull_o <= 1'b0;
      busy_o <= 1'b0;
      start_o <= 1'b0;
      stop_o <= 1'b0;
      wr_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shreg <= shreg_n;
      tx <= tx_n;
      ptr <= ptr_n;
      rw <= rw_n;
      sda_pull_o <= pull_n;
      busy_o <= busy_n;
      start_o <= start_n;
      stop_o <= stop_n;
      wr_o <= wr_n;
    end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      for (int i = 0; i < 2**MEM_AW; i++) mem[i] <= '0;
    end else if (we) begin
      mem[ptr] <= byte_in;
    end
endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb_i2c_slave_mem: bus-level master model with scoreboard checks of i2c_slave_mem
module tb_i2c_slave_mem;
  import i2c_slave_pkg::*;
  localparam int H = 8;
  logic clk = 0, rst_n = 0, scl = 1, sda_m = 1;
  logic sda, sda_pull, busy, start_p, stop_p, wr_p;
  logic [3:0] dbg_addr = '0;
  logic [7:0] dbg_data;
  logic [7:0] bm [16];
  logic ack_q[$];
  logic [7:0] byte_q[$];
  int errors = 0, checks = 0;
  int wr_cnt = 0, pull_cnt = 0, busy_cnt = 0, start_cnt = 0, stop_cnt = 0;

  assign sda = sda_m & ~sda_pull;

  i2c_slave_mem dut (
    .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl), .sda_i(sda),
    .sda_pull_o(sda_pull), .busy_o(busy), .start_o(start_p), .stop_o(stop_p),
    .wr_o(wr_p), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_p) wr_cnt <= wr_cnt + 1;
    if (sda_pull) pull_cnt <= pull_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (start_p) start_cnt <= start_cnt + 1;
    if (stop_p) stop_cnt <= stop_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1; tick(H);
    scl = 1; tick(H);
    sda_m = 0; tick(H);
    scl = 0;
  endtask

  task automatic bus_stop();
    sda_m = 0; tick(H);
    scl = 1; tick(H);
    sda_m = 1; tick(H);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; tick(H);
    scl = 1; tick(H);
    s = sda;
    scl = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clk_bit(mack, s);
  endtask

  task automatic test_reset();
    checks++;
    if ({sda_pull, busy, start_p, stop_p, wr_p} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {sda_pull, busy, start_p, stop_p, wr_p});
    end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i); #1;
      checks++;
      if (dbg_data !== bm[i]) begin
        errors++;
        $display("FAIL reset_mem[%0d]: got %h want %h", i, dbg_data, bm[i]);
      end
    end
  endtask

  task automatic test_write();
    logic ack, e;
    logic [7:0] seq [4] = '{8'h44, 8'h03, 8'hA5, 8'h5A};
    int w0 = wr_cnt, s0 = start_cnt, p0 = stop_cnt;
    bus_start();
    for (int i = 0; i < 4; i++) begin
      ack_q.push_back(I2C_ACK);
      send_byte(seq[i], ack);
      e = ack_q.pop_front();
      checks++;
      if (ack !== e) begin
        errors++;
        $display("FAIL write_ack[%0d]: got %b want %b", i, ack, e);
      end
      if (i == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL write_busy: got %b want 1", busy);
        end
      end
    end
    bm[3] = 8'hA5;
    bm[4] = 8'h5A;
    bus_stop(); tick(4);
    checks++;
    if (wr_cnt - w0 !== 2) begin
      errors++;
      $display("FAIL write_wr_pulses: got %0d want 2", wr_cnt - w0);
    end
    checks++;
    if ({start_cnt - s0, stop_cnt - p0, busy} !== {32'd1, 32'd1, 1'b0}) begin
      errors++;
      $display("FAIL write_start_stop_busy: got %0d %0d %b want 1 1 0", start_cnt - s0, stop_cnt - p0, busy);
    end
    for (int i = 3; i < 5; i++) begin
      dbg_addr = 4'(i); #1;
      checks++;
      if (dbg_data !== bm[i]) begin
        errors++;
        $display("FAIL write_mem[%0d]: got %h want %h", i, dbg_data, bm[i]);
      end
    end
  endtask

  task automatic test_read();
    logic ack, s;
    logic [7:0] d, e;
    logic [7:0] seq [3] = '{8'h44, 8'h03, 8'h45};
    int p0;
    bus_start();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus_start();
      ack_q.push_back(I2C_ACK);
      send_byte(seq[i], ack);
      checks++;
      if (ack !== ack_q[0]) begin
        errors++;
        $display("FAIL read_ack[%0d]: got %b want %b", i, ack, ack_q[0]);
      end
      void'(ack_q.pop_front());
    end
    for (int i = 0; i < 2; i++) begin
      byte_q.push_back(bm[3 + i]);
      recv_byte(i == 0 ? I2C_ACK : I2C_NACK, d);
      e = byte_q.pop_front();
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL read_byte[%0d]: got %h want %h", i, d, e);
      end
    end
    p0 = pull_cnt;
    for (int i = 0; i < 9; i++) clk_bit(1'b1, s);
    checks++;
    if (pull_cnt !== p0) begin
      errors++;
      $display("FAIL read_no_third_byte: got %0d pulled cycles want 0", pull_cnt - p0);
    end
    bus_stop(); tick(4);
    checks++;
    if (dut.ptr !== 4'd5) begin
      errors++;
      $display("FAIL read_final_ptr: got %0d want 5", dut.ptr);
    end
  endtask

  task automatic test_ignore();
    logic ack;
    logic bad = 0;
    int p0 = pull_cnt, b0 = busy_cnt;
    bus_start();
    send_byte(8'h46, ack);
    checks++;
    if (ack !== I2C_NACK) begin
      errors++;
      $display("FAIL ignore_addr_ack: got %b want %b", ack, I2C_NACK);
    end
    send_byte(8'h77, ack);
    bus_stop(); tick(4);
    checks++;
    if (pull_cnt !== p0 || busy_cnt !== b0) begin
      errors++;
      $display("FAIL ignore_bus: got pull=%0d busy=%0d want 0 0", pull_cnt - p0, busy_cnt - b0);
    end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i); #1;
      if (dbg_data !== bm[i]) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ignore_mem: got changed memory want unchanged");
    end
  endtask

  task automatic test_wrap();
    logic ack;
    logic [7:0] seq [4] = '{8'h44, 8'h0F, 8'h11, 8'h22};
    bus_start();
    for (int i = 0; i < 4; i++) begin
      ack_q.push_back(I2C_ACK);
      send_byte(seq[i], ack);
      checks++;
      if (ack !== ack_q[0]) begin
        errors++;
        $display("FAIL wrap_ack[%0d]: got %b want %b", i, ack, ack_q[0]);
      end
      void'(ack_q.pop_front());
    end
    bus_stop(); tick(4);
    bm[15] = 8'h11;
    bm[0] = 8'h22;
    dbg_addr = 4'd15; #1;
    checks++;
    if (dbg_data !== bm[15]) begin
      errors++;
      $display("FAIL wrap_mem15: got %h want %h", dbg_data, bm[15]);
    end
    dbg_addr = 4'd0; #1;
    checks++;
    if (dbg_data !== bm[0]) begin
      errors++;
      $display("FAIL wrap_mem0: got %h want %h", dbg_data, bm[0]);
    end
  endtask

  task automatic test_abort();
    logic ack, s;
    logic [7:0] seq [3] = '{8'h44, 8'h07, 8'h3C};
    int w0 = wr_cnt;
    bus_start();
    send_byte(8'h44, ack);
    send_byte(8'h07, ack);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
    bus_stop(); tick(4);
    checks++;
    if (wr_cnt !== w0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL abort_state: got wr=%0d state=%0d want 0 %0d", wr_cnt - w0, dut.state, IDLE);
    end
    dbg_addr = 4'd7; #1;
    checks++;
    if (dbg_data !== bm[7]) begin
      errors++;
      $display("FAIL abort_mem: got %h want %h", dbg_data, bm[7]);
    end
    bus_start();
    for (int i = 0; i < 3; i++) begin
      ack_q.push_back(I2C_ACK);
      send_byte(seq[i], ack);
      checks++;
      if (ack !== ack_q[0]) begin
        errors++;
        $display("FAIL abort_restart_ack[%0d]: got %b want %b", i, ack, ack_q[0]);
      end
      void'(ack_q.pop_front());
    end
    bus_stop(); tick(4);
    bm[7] = 8'h3C;
    dbg_addr = 4'd7; #1;
    checks++;
    if (dbg_data !== bm[7]) begin
      errors++;
      $display("FAIL abort_restart_mem: got %h want %h", dbg_data, bm[7]);
    end
  endtask

  task automatic test_reset_mid();
    logic ack;
    logic bad = 0;
    int n = 0;
    bus_start();
    send_byte(8'h44, ack);
    send_byte(8'h08, ack);
    bus_start();
    send_byte(8'h45, ack);
    while (sda_pull !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (sda_pull !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_drive: got %b want 1 (bit 7 of 0x%h)", sda_pull, bm[8]);
    end
    rst_n = 0; #1;
    checks++;
    if (sda_pull !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: got %b want 0", sda_pull);
    end
    scl = 1; sda_m = 1;
    tick(3);
    rst_n = 1;
    tick(3);
    for (int i = 0; i < 16; i++) begin
      bm[i] = 8'h00;
      dbg_addr = 4'(i); #1;
      if (dbg_data !== bm[i]) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid_mem: got nonzero memory want all 00");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) bm[i] = 8'h00;
    tick(3);
    rst_n = 1;
    tick(3);
    test_reset();
    test_write();
    test_read();
    test_ignore();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
